dadda_mac_pipe: RTL and testbench

Pipelined, parametrised successor to the 8x8 Dadda multiply-add: computes A*B+M or a running accumulation of A*B over WIDTH-bit unsigned operands. Partial-product generation, Dadda reduction and the final carry-propagate add are split across STAGES register stages. A valid/ready handshake on both sides lets the block sit between a streaming operand source and a result consumer that may stall.

---
 rtl/dadda_mac_pipe.sv | 201 ++++++++++++++++++++
 tb/tb_dadda_mac_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dadda_mac_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : dadda_mac_pipe                                                    |
// | Pipelined WIDTH x WIDTH multiply-add / multiply-accumulate: partial        |
// | products, row-level Dadda reduction and carry-propagate add split over     |
// | STAGES registers behind a single global valid/ready stall.                 |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module dadda_mac_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3,
  parameter int GUARD  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [2*WIDTH-1:0]       m,
  input  logic                     op,
  input  logic                     clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WIDTH+GUARD-1:0] res,
  output logic                     res_ovf
);

  localparam int ACC_W = 2*WIDTH + GUARD;
  localparam int NR    = WIDTH + 1;
  localparam int MID   = STAGES - 2;

  typedef logic [NR-1:0][ACC_W-1:0] rows_t;

  // Largest Dadda height (2,3,4,6,9,13,...) strictly below n.
  function automatic int dadda_below(input int n);
    int d, nx;
    d  = 2;
    nx = 3;
    for (int i = 0; i < 16; i++) begin
      if (nx < n) begin
        d  = nx;
        nx = nx + nx / 2;
      end
    end
    return d;
  endfunction

  function automatic int num_levels(input int n);
    int h, l;
    h = n;
    l = 0;
    for (int i = 0; i < 16; i++) begin
      if (h > 2) begin
        h = dadda_below(h);
        l = l + 1;
      end
    end
    return l;
  endfunction

  localparam int LVL = num_levels(NR);

  function automatic int lvl_lo(input int s);
    if (MID == 0)      return 0;
    else if (s >= MID) return LVL;
    else               return (s * LVL) / MID;
  endfunction

  function automatic int lvl_hi(input int s);
    if (MID == 0 || s >= MID) return LVL;
    else                      return ((s + 1) * LVL) / MID;
  endfunction

  // Applies Dadda levels [lo,hi): each level uses just enough 3:2 row
  // compressors to bring the height down to the next Dadda number.
  function automatic rows_t dadda_reduce(input rows_t r_in, input int lo, input int hi);
    rows_t r, nr;
    int    h, t, c;
    r = r_in;
    h = NR;
    for (int j = 0; j < 16; j++) begin
      if (h > 2) begin
        t = dadda_below(h);
        if (j >= lo && j < hi) begin
          c  = h - t;
          nr = '0;
          for (int k = 0; k < NR / 3; k++) begin
            if (k < c) begin
              nr[2*k]   = r[3*k] ^ r[3*k+1] ^ r[3*k+2];
              nr[2*k+1] = ((r[3*k] & r[3*k+1]) | (r[3*k] & r[3*k+2]) |
                           (r[3*k+1] & r[3*k+2])) << 1;
            end
          end
          for (int k = 0; k < NR; k++) begin
            if (k >= 3*c && k < h) nr[k-c] = r[k];
          end
          r = nr;
        end
        h = t;
      end
    end
    return r;
  endfunction

  logic [STAGES-2:0] vld_q, op_q, clr_q;
  rows_t             rows_q [STAGES-1];
  rows_t             red_w  [STAGES-1];
  rows_t             pp_d;

  logic              out_valid_q, res_ovf_q, sticky_q;
  logic [ACC_W-1:0]  res_q, acc_q;
  logic              res_ovf_d, sticky_d;
  logic [ACC_W-1:0]  res_d, acc_d;
  logic [ACC_W-1:0]  sum_w;
  logic [ACC_W:0]    acc_sum_w;

  assign in_ready  = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign res_ovf   = res_ovf_q;

  always_comb begin
    pp_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pp_d[i] = ACC_W'(a & {WIDTH{b[i]}}) << i;
    end
    pp_d[WIDTH] = op ? '0 : ACC_W'(m);
  end

  always_comb begin
    for (int s = 0; s < STAGES-1; s++) begin
      red_w[s] = dadda_reduce(rows_q[s], lvl_lo(s), lvl_hi(s));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      op_q  <= '0;
      clr_q <= '0;
      for (int s = 0; s < STAGES-1; s++) rows_q[s] <= '0;
    end else if (in_ready) begin
      vld_q[0]  <= in_valid;
      op_q[0]   <= op;
      clr_q[0]  <= clr;
      rows_q[0] <= pp_d;
      for (int s = 1; s < STAGES-1; s++) begin
        vld_q[s]  <= vld_q[s-1];
        op_q[s]   <= op_q[s-1];
        clr_q[s]  <= clr_q[s-1];
        rows_q[s] <= red_w[s-1];
      end
    end
  end

  assign sum_w     = red_w[MID][0] + red_w[MID][1];
  assign acc_sum_w = {1'b0, acc_q} + {1'b0, sum_w};

  // Bubbles leave acc, sticky flag and the held result untouched.
  always_comb begin
    acc_d     = acc_q;
    sticky_d  = sticky_q;
    res_d     = res_q;
    res_ovf_d = res_ovf_q;
    if (vld_q[MID]) begin
      if (!op_q[MID]) begin
        res_d     = sum_w;
        res_ovf_d = 1'b0;
      end else if (clr_q[MID]) begin
        acc_d     = sum_w;
        sticky_d  = 1'b0;
        res_d     = sum_w;
        res_ovf_d = 1'b0;
      end else begin
        acc_d     = acc_sum_w[ACC_W-1:0];
        sticky_d  = sticky_q | acc_sum_w[ACC_W];
        res_d     = acc_sum_w[ACC_W-1:0];
        res_ovf_d = sticky_q | acc_sum_w[ACC_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      res_ovf_q   <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
    end else if (in_ready) begin
      out_valid_q <= vld_q[MID];
      res_q       <= res_d;
      res_ovf_q   <= res_ovf_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dadda_mac_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_dadda_mac_pipe                                                 |
// | Bench for dadda_mac_pipe (WIDTH=8, STAGES=3) with GUARD=8 and GUARD=1.     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_dadda_mac_pipe;

  typedef struct {
    longint res;
    bit     ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [15:0] m = '0;
  logic        op = 1'b0;
  logic        clr = 1'b0;

  logic        ir8, ov8, ovf8;
  logic [23:0] res8;
  logic        ir1, ov1, ovf1;
  logic [16:0] res1;

  int total = 0;
  int bad   = 0;

  exp_t   e8_q[$], e1_q[$], got8_q[$], got1_q[$];
  longint acc8 = 0, acc1 = 0;
  bit     stk8 = 0, stk1 = 0;

  dadda_mac_pipe #(.WIDTH(8), .STAGES(3), .GUARD(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8),
    .a(a), .b(b), .m(m), .op(op), .clr(clr),
    .out_valid(ov8), .out_ready(out_ready), .res(res8), .res_ovf(ovf8)
  );

  dadda_mac_pipe #(.WIDTH(8), .STAGES(3), .GUARD(1)) dut_g1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .a(a), .b(b), .m(m), .op(op), .clr(clr),
    .out_valid(ov1), .out_ready(out_ready), .res(res1), .res_ovf(ovf1)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the accepted beat, in acceptance order.
  function automatic exp_t model(inout longint acc, inout bit stk, input int w);
    longint p, s, lim;
    exp_t   e;
    lim = longint'(1) << w;
    p   = longint'(a) * longint'(b);
    if (!op) begin
      e = '{p + longint'(m), 1'b0};
    end else if (clr) begin
      acc = p;
      stk = 1'b0;
      e   = '{acc, 1'b0};
    end else begin
      s = acc + p;
      if (s >= lim) stk = 1'b1;
      acc = s % lim;
      e   = '{acc, stk};
    end
    return e;
  endfunction

  task automatic model_reset();
    e8_q.delete(); e1_q.delete();
    acc8 = 0; acc1 = 0; stk8 = 0; stk1 = 0;
  endtask

  // One clock: sample at the falling edge, score outputs, record acceptance.
  task automatic cycle(output bit acc_o, output bit ov_o, output bit ir_o);
    @(negedge clk);
    ov_o  = ov8;
    ir_o  = ir8;
    acc_o = in_valid && ir8;
    if (ov8) begin
      total++;
      assert (e8_q.size() > 0) else begin
        bad++;
        $error("FAIL out8_spurious got=valid want=idle");
      end
      if (e8_q.size() > 0) begin
        chk("res8", res8, e8_q[0].res);
        chk("ovf8", ovf8, e8_q[0].ovf);
        if (out_ready) begin
          got8_q.push_back('{longint'(res8), ovf8});
          void'(e8_q.pop_front());
        end
      end
    end
    if (ov1) begin
      total++;
      assert (e1_q.size() > 0) else begin
        bad++;
        $error("FAIL out1_spurious got=valid want=idle");
      end
      if (e1_q.size() > 0) begin
        chk("res1", res1, e1_q[0].res);
        chk("ovf1", ovf1, e1_q[0].ovf);
        if (out_ready) begin
          got1_q.push_back('{longint'(res1), ovf1});
          void'(e1_q.pop_front());
        end
      end
    end
    if (acc_o) begin
      e8_q.push_back(model(acc8, stk8, 24));
      e1_q.push_back(model(acc1, stk1, 17));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit op_i, input bit clr_i, input int ai, input int bi, input int mi);
    bit ac, ov, ir;
    op = op_i; clr = clr_i; a = 8'(ai); b = 8'(bi); m = 16'(mi);
    in_valid = 1'b1;
    ac = 1'b0;
    for (int n = 0; n < 50 && !ac; n++) cycle(ac, ov, ir);
    chk("send_accepted", ac, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    bit ac, ov, ir;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < max_cyc && (e8_q.size() > 0 || e1_q.size() > 0); i++) cycle(ac, ov, ir);
    chk("drain8_left", e8_q.size(), 0);
    chk("drain1_left", e1_q.size(), 0);
  endtask

  initial begin
    bit ac, ov, ir, seen, dropped;
    int stall, sent;
    int sa[6], sb[6], sm[6];

    // Reset state, observed while rst_n is still low.
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", ov8, 0);
    chk("rst_res", res8, 0);
    chk("rst_res_ovf", ovf8, 0);
    chk("rst_in_ready", ir8, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: handshake cycle, then out_valid after the third edge.
    got8_q.delete(); got1_q.delete();
    op = 0; clr = 0; a = 8'd255; b = 8'd255; m = 16'hFFFF;
    in_valid = 1'b1;
    cycle(ac, ov, ir);
    chk("lat_accept", ac, 1);
    in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cycle(ac, ov, ir);
      chk($sformatf("lat_valid_edge%0d", i), ov, (i == 3));
    end
    chk("lat_count", got8_q.size(), 1);
    if (got8_q.size() == 1) begin
      chk("lat_res", got8_q[0].res, 130560);
      chk("lat_ovf", got8_q[0].ovf, 0);
    end
    drain(20);

    // Accumulate sequence; the op=0 beat carries clr=1, which must be ignored.
    got8_q.delete(); got1_q.delete();
    send(1, 1, 10, 20, 0);
    send(1, 0, 3, 4, 0);
    send(0, 1, 2, 2, 1);
    send(1, 0, 1, 1, 0);
    drain(20);
    chk("accum_count", got8_q.size(), 4);
    if (got8_q.size() == 4) begin
      chk("accum_r0", got8_q[0].res, 200);
      chk("accum_r1", got8_q[1].res, 212);
      chk("accum_r2", got8_q[2].res, 5);
      chk("accum_r3", got8_q[3].res, 213);
    end

    // Back-to-back stream with a 5-cycle consumer stall after first out_valid.
    got8_q.delete(); got1_q.delete();
    for (int i = 0; i < 6; i++) begin
      sa[i] = int'($urandom_range(0, 255));
      sb[i] = int'($urandom_range(0, 255));
      sm[i] = int'($urandom_range(0, 65535));
    end
    seen = 0; dropped = 0; stall = 0; sent = 0;
    for (int cyc = 0; cyc < 60 && (sent < 6 || e8_q.size() > 0); cyc++) begin
      if (ov8) seen = 1;
      out_ready = !(seen && stall < 5);
      if (seen && stall < 5) stall++;
      in_valid = (sent < 6);
      if (sent < 6) begin
        op = 0; clr = 0; a = 8'(sa[sent]); b = 8'(sb[sent]); m = 16'(sm[sent]);
      end
      cycle(ac, ov, ir);
      if (ac) sent++;
      if (!ir && !dropped) begin
        dropped = 1;
        chk("stall_beats_held", e8_q.size(), 3);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stall_ready_dropped", dropped, 1);
    chk("stall_count", got8_q.size(), 6);
    for (int i = 0; i < 6 && i < got8_q.size(); i++)
      chk($sformatf("stall_order%0d", i), got8_q[i].res, sa[i] * sb[i] + sm[i]);
    drain(20);

    // Wrap-around on the 17-bit accumulator.
    got8_q.delete(); got1_q.delete();
    send(1, 1, 255, 255, 0);
    send(1, 0, 255, 255, 0);
    send(1, 0, 255, 255, 0);
    send(1, 1, 1, 1, 0);
    drain(20);
    chk("ovf_count", got1_q.size(), 4);
    if (got1_q.size() == 4) begin
      chk("ovf_r0", got1_q[0].res, 65025);  chk("ovf_f0", got1_q[0].ovf, 0);
      chk("ovf_r1", got1_q[1].res, 130050); chk("ovf_f1", got1_q[1].ovf, 0);
      chk("ovf_r2", got1_q[2].res, 64003);  chk("ovf_f2", got1_q[2].ovf, 1);
      chk("ovf_r3", got1_q[3].res, 1);      chk("ovf_f3", got1_q[3].ovf, 0);
    end

    // Mid-stream reset: acc=500 loaded, two more beats in flight.
    got8_q.delete(); got1_q.delete();
    send(1, 1, 20, 25, 0);
    cycle(ac, ov, ir);
    send(0, 0, 7, 9, 11);
    send(1, 0, 5, 5, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", ov8, 0);
    chk("midrst_res", res8, 0);
    model_reset();
    got8_q.delete(); got1_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(1, 0, 2, 3, 0);
    drain(20);
    chk("midrst_count", got8_q.size(), 1);
    if (got8_q.size() == 1) chk("midrst_res_after", got8_q[0].res, 6);

    // Random stress against the reference model on both guard widths.
    for (int cyc = 0; cyc < 500; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      op  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 7) == 0);
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      m   = 16'($urandom_range(0, 65535));
      cycle(ac, ov, ir);
    end
    drain(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
